// File: rtl/mem_access.sv
// Memory-access stage: runs one load or store per instruction over a req/gnt/rvalid
// bus, with byte-lane steering, load extension, and misalignment/timeout faults.
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        ctrl_memread,
  input  logic        ctrl_memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        mem_op, is_store, fault, tmo_fire;
  logic [31:0] wdata_c, load_ext;
  logic [3:0]  wstrb_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Decode of the instruction presented in IDLE; both control bits set means load.
  always_comb begin
    mem_op   = in_valid & (ctrl_memread | ctrl_memwrite);
    is_store = ctrl_memwrite & ~ctrl_memread;
    fault    = (funct3[1:0] == 2'b11)
             | (is_store & funct3[2])
             | ((funct3[1:0] == 2'b01) & alu_result[0])
             | ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00));
    wdata_c  = rdata2;
    wstrb_c  = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_c = {4{rdata2[7:0]}};
        wstrb_c = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        wdata_c = {2{rdata2[15:0]}};
        wstrb_c = 4'b0011 << {alu_result[1], 1'b0};
      end
      default: ;
    endcase
    if (!is_store) wstrb_c = 4'b0000;
  end

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (off_q)
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      2'd3:    byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext = f3_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = f3_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Bus handshake: dmem_req stays high with every dmem_* field stable until a cycle
  // where dmem_gnt is high; dmem_rvalid is honoured only in RESP, i.e. no earlier
  // than the cycle after the grant. A handshake event beats a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE: if (mem_op) state_d = fault ? DONE : REQ;
      REQ: begin
        if (dmem_gnt) state_d = RESP;
        else if (cnt_q >= TMO_LAST) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      RESP: begin
        if (dmem_rvalid) state_d = DONE;
        else if (cnt_q >= TMO_LAST) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dmem_req  = (state_q == REQ);
  assign lsu_done  = (state_q == DONE);
  assign lsu_busy  = ~rst & ((state_q == REQ) | (state_q == RESP) | ((state_q == IDLE) & mem_op));
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_wstrb <= 4'd0;
      load_data  <= 32'd0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_op) begin
        cnt_q      <= 8'd0;
        f3_q       <= funct3;
        off_q      <= alu_result[1:0];
        dmem_we    <= is_store;
        dmem_addr  <= {alu_result[31:2], 2'b00};
        dmem_wdata <= wdata_c;
        dmem_wstrb <= wstrb_c;
        load_data  <= 32'd0;
        misaligned <= fault;
        bus_err    <= 1'b0;
      end
      if (state_q == REQ || state_q == RESP) begin
        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        if (tmo_fire) bus_err <= 1'b1;
      end
      // Stores leave load_data at the zero written on accept.
      if (state_q == RESP && dmem_rvalid && !dmem_we) load_data <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scripted bus responses, an expected-result
// queue of {bus_err, misaligned, load_data}, and a one-line final report.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, ctrl_memread, ctrl_memwrite;
  logic [2:0]  funct3;
  logic [31:0] alu_result, rdata2;
  logic        lsu_busy, lsu_done, misaligned, bus_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ctrl_memread(ctrl_memread),
    .ctrl_memwrite(ctrl_memwrite), .funct3(funct3), .alu_result(alu_result),
    .rdata2(rdata2), .lsu_busy(lsu_busy), .lsu_done(lsu_done), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
    in_valid = 1'b1; ctrl_memread = rd; ctrl_memwrite = wr;
    funct3 = f3; alu_result = addr; rdata2 = wd;
  endtask

  task automatic clear_op();
    in_valid = 1'b0; ctrl_memread = 1'b0; ctrl_memwrite = 1'b0;
  endtask

  // Full access with a grant after 0..1 extra REQ cycles and rvalid right after it.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, output logic seen,
                           output logic [33:0] got, output int req_cycles);
    int dly;
    logic granted;
    dly = int'($urandom_range(0, 1));
    granted = 1'b0; seen = 1'b0; got = '0; req_cycles = 0;
    @(negedge clk);
    drive_op(rd, wr, f3, addr, wd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) clear_op();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1;
      if (lsu_done) begin
        seen = 1'b1;
        got = {bus_err, misaligned, load_data};
        break;
      end
      if (granted) begin
        dmem_rvalid = 1'b1; dmem_rdata = rword; granted = 1'b0;
      end else if (dmem_req) begin
        req_cycles++;
        if (dly == 0) begin dmem_gnt = 1'b1; granted = 1'b1; end
        else dly--;
      end
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_op(1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (lsu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", lsu_busy); end
    checks++; if ({dmem_req, dmem_we, lsu_done, misaligned, bus_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 00000", {dmem_req, dmem_we, lsu_done, misaligned, bus_err}); end
    checks++; if ({dmem_addr, dmem_wdata, dmem_wstrb, load_data} !== 100'b0) begin
      failures++; $display("FAIL reset_data: addr %h wdata %h wstrb %b load %h want all 0", dmem_addr, dmem_wdata, dmem_wstrb, load_data); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    clear_op();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lb();
    logic [33:0] exp;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0);
    exp_q.push_back({2'b00, 32'hFFFF_FF80});
    #1;
    checks++; if (lsu_busy !== 1'b1) begin failures++; $display("FAIL lb_c0_busy: got %b want 1", lsu_busy); end
    @(negedge clk);
    clear_op();
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_wstrb} !== 6'b100000) begin
      failures++; $display("FAIL lb_c1_bus: req %b we %b wstrb %b want 1 0 0000", dmem_req, dmem_we, dmem_wstrb); end
    checks++; if (dmem_addr !== 32'h0000_1000) begin failures++; $display("FAIL lb_addr: got %h want 00001000", dmem_addr); end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
    #1;
    checks++; if ({lsu_done, lsu_busy} !== 2'b01) begin
      failures++; $display("FAIL lb_c2: done %b busy %b want 0 1", lsu_done, lsu_busy); end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    checks++; if ({lsu_done, lsu_busy} !== 2'b10) begin
      failures++; $display("FAIL lb_c3: done %b busy %b want 1 0", lsu_done, lsu_busy); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL lb_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if ({bus_err, misaligned, load_data} !== exp) begin
        failures++; $display("FAIL lb_result: got %h want %h", {bus_err, misaligned, load_data}, exp); end
    end
  endtask

  task automatic test_sh();
    logic [33:0] exp;
    @(negedge clk);
    drive_op(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF);
    exp_q.push_back({2'b00, 32'h0});
    @(negedge clk);
    clear_op();
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_wstrb} !== 6'b111100) begin
      failures++; $display("FAIL sh_bus: req %b we %b wstrb %b want 1 1 1100", dmem_req, dmem_we, dmem_wstrb); end
    checks++; if ({dmem_addr, dmem_wdata} !== {32'h0000_2000, 32'hBEEF_BEEF}) begin
      failures++; $display("FAIL sh_data: addr %h wdata %h want 00002000 beefbeef", dmem_addr, dmem_wdata); end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL sh_done: got %b want 1", lsu_done); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL sh_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if ({bus_err, misaligned, load_data} !== exp) begin
        failures++; $display("FAIL sh_result: got %h want %h", {bus_err, misaligned, load_data}, exp); end
    end
  endtask

  task automatic test_misaligned();
    logic [33:0] exp;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0);
    exp_q.push_back({2'b01, 32'h0});
    #1;
    checks++; if ({lsu_busy, dmem_req} !== 2'b10) begin
      failures++; $display("FAIL mis_c0: busy %b req %b want 1 0", lsu_busy, dmem_req); end
    @(negedge clk);
    clear_op();
    #1;
    checks++; if ({lsu_done, dmem_req, lsu_busy} !== 3'b100) begin
      failures++; $display("FAIL mis_c1: done %b req %b busy %b want 1 0 0", lsu_done, dmem_req, lsu_busy); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL mis_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if ({bus_err, misaligned, load_data} !== exp) begin
        failures++; $display("FAIL mis_result: got %h want %h", {bus_err, misaligned, load_data}, exp); end
    end
    @(negedge clk);
    #1;
    checks++; if ({lsu_done, lsu_busy, dmem_req} !== 3'b000) begin
      failures++; $display("FAIL mis_c2: done %b busy %b req %b want 0 0 0", lsu_done, lsu_busy, dmem_req); end
  endtask

  task automatic test_faults();
    logic [2:0]  f3_t [6];
    logic        wr_t [6];
    logic [31:0] ad_t [6];
    logic        seen;
    logic [33:0] got, exp;
    int          reqs;
    f3_t = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    wr_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ad_t = '{32'h7001, 32'h7003, 32'h7002, 32'h7000, 32'h7000, 32'h7002};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({2'b01, 32'h0});
      do_access(~wr_t[i], wr_t[i], f3_t[i], ad_t[i], 32'h1111_2222, 32'h0, seen, got, reqs);
      checks++;
      if (!seen || reqs != 0) begin
        failures++; $display("FAIL fault_%0d: done_seen %b req_cycles %0d want 1 0", i, seen, reqs); end
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL fault_%0d_result: expected queue empty", i); end
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin failures++; $display("FAIL fault_%0d_result: got %h want %h", i, got, exp); end
      end
    end
    // Both control bits set behaves as a load.
    exp_q.push_back({2'b00, 32'hFFFF_FFAB});
    do_access(1'b1, 1'b1, 3'd0, 32'h7002, 32'h0, 32'h00AB_0000, seen, got, reqs);
    checks++;
    if (!seen || dmem_we !== 1'b0 || dmem_wstrb !== 4'b0) begin
      failures++; $display("FAIL both_bits: done_seen %b we %b wstrb %b want 1 0 0000", seen, dmem_we, dmem_wstrb); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL both_bits_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin failures++; $display("FAIL both_bits_result: got %h want %h", got, exp); end
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3_t  [10];
    logic [1:0]  off_t [10];
    logic [31:0] exp_t [10];
    logic [31:0] base;
    logic        seen;
    logic [33:0] got, exp;
    int          reqs;
    f3_t  = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd1, 3'd5, 3'd1, 3'd5, 3'd2};
    off_t = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
    exp_t = '{32'h0000_0001, 32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_007F, 32'hFFFF_FF8C,
              32'hFFFF_F001, 32'h0000_8C7F, 32'hFFFF_8C7F, 32'h0000_F001, 32'h8C7F_F001};
    for (int i = 0; i < 10; i++) begin
      base = 32'($urandom_range(0, 4095)) << 4;
      exp_q.push_back({2'b00, exp_t[i]});
      do_access(1'b1, 1'b0, f3_t[i], base | {30'd0, off_t[i]}, 32'h0, 32'h8C7F_F001, seen, got, reqs);
      checks++;
      if (!seen || dmem_addr !== base || dmem_wstrb !== 4'b0) begin
        failures++; $display("FAIL ld_%0d_bus: done_seen %b addr %h wstrb %b want 1 %h 0000", i, seen, dmem_addr, dmem_wstrb, base); end
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL ld_%0d_result: expected queue empty", i); end
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin failures++; $display("FAIL ld_%0d_result: got %h want %h", i, got, exp); end
      end
    end
  endtask

  task automatic test_store_steer();
    logic [2:0]  f3_t  [5];
    logic [1:0]  off_t [5];
    logic [31:0] wd_t  [5];
    logic [3:0]  st_t  [5];
    logic [31:0] base;
    logic        seen;
    logic [33:0] got, exp;
    int          reqs;
    f3_t  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    off_t = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd0};
    wd_t  = '{32'h7878_7878, 32'h7878_7878, 32'h5678_5678, 32'h5678_5678, 32'h1234_5678};
    st_t  = '{4'b0001, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      base = 32'($urandom_range(0, 4095)) << 4;
      exp_q.push_back({2'b00, 32'h0});
      do_access(1'b0, 1'b1, f3_t[i], base | {30'd0, off_t[i]}, 32'h1234_5678, 32'hFFFF_FFFF, seen, got, reqs);
      checks++;
      if (!seen || dmem_we !== 1'b1 || dmem_wdata !== wd_t[i] || dmem_wstrb !== st_t[i]) begin
        failures++; $display("FAIL st_%0d_bus: done_seen %b we %b wdata %h wstrb %b want 1 1 %h %b",
                             i, seen, dmem_we, dmem_wdata, dmem_wstrb, wd_t[i], st_t[i]); end
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL st_%0d_result: expected queue empty", i); end
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin failures++; $display("FAIL st_%0d_result: got %h want %h", i, got, exp); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [33:0] exp;
    logic        seen, granted;
    int          req_cnt;
    // No grant at all: bus_err after TMO request cycles.
    seen = 1'b0; req_cnt = 0;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'd0, 32'h0000_5000, 32'h0);
    exp_q.push_back({2'b10, 32'h0});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clear_op();
      #1;
      if (lsu_done) begin seen = 1'b1; break; end
      if (dmem_req) req_cnt++;
    end
    checks++;
    if (!seen || req_cnt != TMO || dmem_req !== 1'b0) begin
      failures++; $display("FAIL tmo_req_cycles: done_seen %b req_cycles %0d req %b want 1 %0d 0", seen, req_cnt, dmem_req, TMO); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL tmo_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if ({bus_err, misaligned, load_data} !== exp) begin
        failures++; $display("FAIL tmo_result: got %h want %h", {bus_err, misaligned, load_data}, exp); end
    end
    // Grant arrives in the last allowed request cycle: the handshake wins.
    seen = 1'b0; req_cnt = 0; granted = 1'b0;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'd2, 32'h0000_5004, 32'h0);
    exp_q.push_back({2'b00, 32'h1357_2468});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clear_op();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1;
      if (lsu_done) begin seen = 1'b1; break; end
      if (granted) begin
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_2468; granted = 1'b0;
      end else if (dmem_req) begin
        req_cnt++;
        if (req_cnt == TMO) begin dmem_gnt = 1'b1; granted = 1'b1; end
      end
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    checks++;
    if (!seen || req_cnt != TMO) begin
      failures++; $display("FAIL tmo_late_gnt: done_seen %b req_cycles %0d want 1 %0d", seen, req_cnt, TMO); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL tmo_late_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if ({bus_err, misaligned, load_data} !== exp) begin
        failures++; $display("FAIL tmo_late_result: got %h want %h", {bus_err, misaligned, load_data}, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic        seen, any_done;
    logic [33:0] got, exp;
    int          reqs;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'd5, 32'h0000_4002, 32'h0);
    @(negedge clk);
    clear_op();
    #1;
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rmid_req: got %b want 1", dmem_req); end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (lsu_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy_in_rst: got %b want 0", lsu_busy); end
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
    #1;
    checks++; if ({dmem_req, dmem_we, lsu_done, misaligned, bus_err, dmem_addr, dmem_wdata, dmem_wstrb, load_data} !== 105'b0) begin
      failures++; $display("FAIL rmid_outputs: req %b done %b addr %h load %h want all 0", dmem_req, lsu_done, dmem_addr, load_data); end
    any_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_rvalid = 1'b0;
      #1;
      if (lsu_done || dmem_req) any_done = 1'b1;
    end
    checks++; if (any_done !== 1'b0) begin failures++; $display("FAIL rmid_late_rvalid: done_or_req %b want 0", any_done); end
    exp_q.push_back({2'b00, 32'h0000_8001});
    do_access(1'b1, 1'b0, 3'd5, 32'h0000_4002, 32'h0, 32'h8001_0000, seen, got, reqs);
    checks++;
    if (!seen) begin failures++; $display("FAIL rmid_retry_done: got %b want 1", seen); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL rmid_retry_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin failures++; $display("FAIL rmid_retry_result: got %h want %h", got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp;
    int          pulses;
    pulses = 0;
    @(negedge clk);                                      // C0: sw accepted
    drive_op(1'b0, 1'b1, 3'd2, 32'h0000_6000, 32'hCAFE_F00D);
    exp_q.push_back({2'b00, 32'h0});
    #1; pulses += int'(lsu_done);
    @(negedge clk);                                      // C1: REQ, lbu waiting
    drive_op(1'b1, 1'b0, 3'd4, 32'h0000_6001, 32'h0);
    #1; pulses += int'(lsu_done);
    checks++; if ({dmem_req, dmem_we, dmem_wstrb, dmem_wdata} !== {6'b111111, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL b2b_sw_bus: req %b we %b wstrb %b wdata %h want 1 1 1111 cafef00d", dmem_req, dmem_we, dmem_wstrb, dmem_wdata); end
    dmem_gnt = 1'b1;
    @(negedge clk);                                      // C2: RESP
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1; pulses += int'(lsu_done);
    @(negedge clk);                                      // C3: DONE for sw
    dmem_rvalid = 1'b0;
    #1; pulses += int'(lsu_done);
    checks++; if ({lsu_done, lsu_busy} !== 2'b10) begin
      failures++; $display("FAIL b2b_sw_done: done %b busy %b want 1 0", lsu_done, lsu_busy); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_sw_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if ({bus_err, misaligned, load_data} !== exp) begin
        failures++; $display("FAIL b2b_sw_result: got %h want %h", {bus_err, misaligned, load_data}, exp); end
    end
    exp_q.push_back({2'b00, 32'h0000_00A5});
    @(negedge clk);                                      // C4: lbu accepted
    #1; pulses += int'(lsu_done);
    checks++; if ({lsu_busy, dmem_req} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept: busy %b req %b want 1 0", lsu_busy, dmem_req); end
    @(negedge clk);                                      // C5: REQ for lbu
    clear_op();
    #1; pulses += int'(lsu_done);
    checks++; if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr} !== {6'b100000, 32'h0000_6000}) begin
      failures++; $display("FAIL b2b_lbu_bus: req %b we %b wstrb %b addr %h want 1 0 0000 00006000", dmem_req, dmem_we, dmem_wstrb, dmem_addr); end
    dmem_gnt = 1'b1;
    @(negedge clk);                                      // C6: RESP
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_A500;
    #1; pulses += int'(lsu_done);
    @(negedge clk);                                      // C7: DONE for lbu
    dmem_rvalid = 1'b0;
    #1; pulses += int'(lsu_done);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_lbu_result: expected queue empty"); end
    else begin
      exp = exp_q.pop_front();
      if ({lsu_done, bus_err, misaligned, load_data} !== {1'b1, exp}) begin
        failures++; $display("FAIL b2b_lbu_result: done %b got %h want 1 %h", lsu_done, {bus_err, misaligned, load_data}, exp); end
    end
    @(negedge clk);
    #1; pulses += int'(lsu_done);
    checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_done_pulses: got %0d want 2", pulses); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; ctrl_memread = 1'b0; ctrl_memwrite = 1'b0;
    funct3 = 3'd0; alu_result = 32'd0; rdata2 = 32'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_faults();
    test_load_ext();
    test_store_steer();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
